// File: rtl/switches_arb_pkg.sv
// Shared types and defaults for the switches PIO round-robin read arbiter.
package switches_arb_pkg;

    localparam int unsigned DEF_NUM_MASTERS = 4;
    localparam int unsigned DEF_ADDR_W      = 2;
    localparam int unsigned DEF_DATA_W      = 32;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StCapt,
        StResp
    } arb_state_e;

    // Grant index width; kept at least 1 so a single-bit index is still legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_IDX_W = idx_width(DEF_NUM_MASTERS);

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after ptr, with wrap.
module rr_priority_pick #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned IDX_W       = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic                   valid,
    output logic [IDX_W-1:0]       winner
);

    logic [2*NUM_MASTERS-1:0] req_dbl;
    logic [NUM_MASTERS-1:0]   req_rot;

    // Rotate so bit 0 of req_rot is the highest-priority master.
    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[NUM_MASTERS-1:0];

    always_comb begin
        int unsigned sum;
        valid  = 1'b0;
        winner = '0;
        sum    = 0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (!valid && req_rot[i]) begin
                valid = 1'b1;
                sum   = int'(ptr) + i;
                if (sum >= NUM_MASTERS) begin
                    sum = sum - NUM_MASTERS;
                end
                winner = IDX_W'(sum);
            end
        end
    end

endmodule

// File: rtl/switches_rr_arbiter.sv
// Round-robin arbiter sharing the switches PIO s1 read port among several cores;
// each grant runs ADDR -> CAPT -> RESP around the PIO's registered read path.
module switches_rr_arbiter
    import switches_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
    output logic [NUM_MASTERS-1:0]        m_waitrequest,
    output logic [DATA_W-1:0]             m_readdata,
    output logic [ADDR_W-1:0]             s_address,
    input  logic [DATA_W-1:0]             s_readdata,
    output logic                          busy
);

    localparam int unsigned IDX_W = idx_width(NUM_MASTERS);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, grant_idx_q;
    logic [IDX_W-1:0] rr_ptr_next;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             grant_en;
    logic             capt_en;

    rr_priority_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_pick (
        .req    (m_read),
        .ptr    (rr_ptr_q),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    assign rr_ptr_next = (int'(pick_idx) == NUM_MASTERS - 1) ? '0 : pick_idx + 1'b1;

    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        capt_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_en = 1'b1;
                    state_d  = StAddr;
                end
            end
            StAddr: state_d = StCapt;
            StCapt: begin
                capt_en = 1'b1;
                state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            s_address   <= '0;
            m_readdata  <= '0;
        end else begin
            state_q <= state_d;
            if (grant_en) begin
                grant_idx_q <= pick_idx;
                rr_ptr_q    <= rr_ptr_next;
                s_address   <= m_address[pick_idx*ADDR_W +: ADDR_W];
            end
            if (capt_en) begin
                m_readdata <= s_readdata;
            end
        end
    end

    // Registered-only decode: no combinational path from m_read.
    always_comb begin
        m_waitrequest = '1;
        if (state_q == StResp) begin
            m_waitrequest[grant_idx_q] = 1'b0;
        end
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_switches_rr_arbiter.sv
// Self-checking bench for switches_rr_arbiter with a small PIO model and a
// round-robin reference model kept as plain integers.
module tb_switches_rr_arbiter;

    localparam int NM = 4;
    localparam int AW = 2;
    localparam int DW = 32;

    logic              clk;
    logic              reset_n;
    logic [NM-1:0]     m_read;
    logic [NM*AW-1:0]  m_address;
    logic [NM-1:0]     m_waitrequest;
    logic [DW-1:0]     m_readdata;
    logic [AW-1:0]     s_address;
    logic [DW-1:0]     s_readdata;
    logic              busy;

    logic [7:0] in_port;
    logic [7:0] in_sync;

    int checks = 0;
    int errors = 0;
    int rr_ptr_m = 0;
    logic [DW-1:0] last_data = '0;

    switches_rr_arbiter #(
        .NUM_MASTERS (NM),
        .ADDR_W      (AW),
        .DATA_W      (DW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .m_read        (m_read),
        .m_address     (m_address),
        .m_waitrequest (m_waitrequest),
        .m_readdata    (m_readdata),
        .s_address     (s_address),
        .s_readdata    (s_readdata),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PIO model: synchronised switch input, registered readdata, zero for addr != 0.
    always @(posedge clk) begin
        in_sync    <= in_port;
        s_readdata <= (s_address == 2'd0) ? {24'h0, in_sync} : 32'h0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pick(input logic [NM-1:0] req);
        for (int k = 0; k < NM; k++) begin
            int idx;
            idx = (rr_ptr_m + k) % NM;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    // One IDLE visit starting now; pin_c1/pin_c2 are switch values applied in ADDR/CAPT.
    task automatic run_txn(input logic [NM-1:0] req, input logic [NM*AW-1:0] addrs,
                           input logic [7:0] pin, input logic [7:0] pin_c1,
                           input logic [7:0] pin_c2, input bit scramble);
        int w;
        logic [AW-1:0] a;
        logic [DW-1:0] exp_data;
        logic [NM-1:0] exp_wr;
        m_read    = req;
        m_address = addrs;
        in_port   = pin;
        checks++;
        if (m_waitrequest !== 4'hF || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_cycle: wr=%b busy=%b required wr=1111 busy=0", m_waitrequest, busy);
        end
        w = model_pick(req);
        if (w < 0) begin
            step();
            checks++;
            if (busy !== 1'b0 || m_waitrequest !== 4'hF) begin
                errors++;
                $display("FAIL no_req_stays_idle: busy=%b wr=%b required 0/1111", busy, m_waitrequest);
            end
            m_read = '0;
            return;
        end
        a        = addrs[w*AW +: AW];
        exp_data = (a == 2'd0) ? {24'h0, pin} : 32'h0;
        rr_ptr_m = (w + 1) % NM;

        step();  // ADDR
        checks++;
        if (s_address !== a || busy !== 1'b1 || m_waitrequest !== 4'hF || m_readdata !== last_data) begin
            errors++;
            $display("FAIL addr_cycle: s_addr=%0d busy=%b wr=%b rd=%h required %0d 1 1111 %h",
                     s_address, busy, m_waitrequest, m_readdata, a, last_data);
        end
        in_port = pin_c1;
        if (scramble) begin
            m_read    = NM'($urandom);
            m_address = (NM*AW)'($urandom);
        end

        step();  // CAPT
        checks++;
        if (busy !== 1'b1 || m_waitrequest !== 4'hF || m_readdata !== last_data) begin
            errors++;
            $display("FAIL capt_cycle: busy=%b wr=%b rd=%h required 1 1111 %h",
                     busy, m_waitrequest, m_readdata, last_data);
        end
        in_port = pin_c2;

        step();  // RESP
        exp_wr    = '1;
        exp_wr[w] = 1'b0;
        checks++;
        if (m_waitrequest !== exp_wr || m_readdata !== exp_data || busy !== 1'b1) begin
            errors++;
            $display("FAIL resp_cycle: wr=%b rd=%h busy=%b required wr=%b rd=%h busy=1",
                     m_waitrequest, m_readdata, busy, exp_wr, exp_data);
        end
        last_data = exp_data;

        step();  // back in IDLE
        m_read = '0;
        checks++;
        if (m_waitrequest !== 4'hF || busy !== 1'b0 || m_readdata !== last_data) begin
            errors++;
            $display("FAIL post_resp: wr=%b busy=%b rd=%h required 1111 0 %h",
                     m_waitrequest, busy, m_readdata, last_data);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        m_read    = 4'hF;
        m_address = 8'hFF;
        in_port   = 8'h00;
        step();
        step();
        checks++;
        if (m_waitrequest !== 4'hF || m_readdata !== 32'h0 || s_address !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: wr=%b rd=%h s_addr=%0d busy=%b required 1111 0 0 0",
                     m_waitrequest, m_readdata, s_address, busy);
        end
        m_read  = '0;
        reset_n = 1'b1;
        step();
        rr_ptr_m  = 0;
        last_data = '0;
    endtask

    task automatic test_single();
        run_txn(4'b0001, 8'h00, 8'hA5, 8'hA5, 8'hA5, 1'b0);
    endtask

    task automatic test_all_four();
        for (int i = 0; i < NM; i++) begin
            run_txn(4'b1111, 8'h00, 8'h3C, 8'h3C, 8'h3C, 1'b0);
        end
    endtask

    task automatic test_fairness();
        run_txn(4'b0100, 8'h00, 8'h42, 8'h42, 8'h42, 1'b0);
        run_txn(4'b1100, 8'h00, 8'h43, 8'h43, 8'h43, 1'b0);
        run_txn(4'b0100, 8'h00, 8'h44, 8'h44, 8'h44, 1'b0);
    endtask

    task automatic test_addr1();
        run_txn(4'b0010, 8'b00_00_01_00, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    endtask

    task automatic test_switch_change();
        run_txn(4'b0001, 8'h00, 8'h11, 8'h22, 8'h33, 1'b0);
    endtask

    task automatic test_reset_mid();
        // Leave a nonzero m_readdata behind so the reset clear is visible.
        run_txn(4'b0010, 8'h00, 8'h77, 8'h77, 8'h77, 1'b0);
        m_read    = 4'b0001;
        m_address = 8'h00;
        in_port   = 8'h5A;
        step();  // ADDR
        m_read = '0;
        step();  // CAPT
        reset_n = 1'b0;
        step();
        checks++;
        if (m_waitrequest !== 4'hF || m_readdata !== 32'h0 || busy !== 1'b0 || s_address !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid: wr=%b rd=%h busy=%b s_addr=%0d required 1111 0 0 0",
                     m_waitrequest, m_readdata, busy, s_address);
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (m_waitrequest !== 4'hF || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_resp: wr=%b busy=%b required 1111 0", m_waitrequest, busy);
        end
        rr_ptr_m  = 0;
        last_data = '0;
        run_txn(4'b1001, 8'h00, 8'h61, 8'h61, 8'h61, 1'b0);
        run_txn(4'b1000, 8'h00, 8'h62, 8'h62, 8'h62, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [NM-1:0]    req;
            logic [NM*AW-1:0] addrs;
            req   = NM'($urandom_range(0, 15));
            addrs = '0;
            for (int m = 0; m < NM; m++) begin
                if ($urandom_range(0, 3) == 0) addrs[m*AW +: AW] = AW'($urandom);
            end
            run_txn(req, addrs, 8'($urandom), 8'($urandom), 8'($urandom),
                    $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        m_read    = '0;
        m_address = '0;
        in_port   = '0;
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_addr1();
        test_switch_change();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
